// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - single-port DRAM arbiter for icache refill and dcache refill/writeback
//
// Runs one aligned cache-line burst at a time on the DRAM port, steers beats
// to/from the granted cache and raises transfer_in_progress while busy.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ic_req/ic_addr          icache line-read request and miss address
//   ic_grant/ic_done        one-cycle pulses at burst start / completion
//   ic_rvalid/ic_rdata      read beat towards the icache
//   dc_req/dc_we/dc_addr    dcache request (we=1 writeback, we=0 read)
//   dc_wdata/dc_wready      write beat source and its consume strobe
//   dc_grant/dc_done        one-cycle pulses at burst start / completion
//   dc_rvalid/dc_rdata      read beat towards the dcache
//   mem_*                   DRAM controller side, one beat per mem_ack
//   transfer_in_progress    high whenever the arbiter is not idle
//
// Configuration macro: DRAM_ARB_ROUND_ROBIN_EN
//   defined   - ties go to the side not served last
//   undefined - fixed priority, dcache wins ties

module dram_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_grant,
    output logic              ic_rvalid,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wready,
    output logic              dc_grant,
    output logic              dc_rvalid,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              transfer_in_progress
);

    localparam int BW  = $clog2(BURST_LEN);
    localparam int OFF = BW + 2;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        IC_BURST,
        DC_BURST,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [BW-1:0]     beat, beat_next;
    logic [ADDR_W-1:0] base, base_next;
    logic              we_r, we_next;
    logic              dc_served, dc_served_next;
    logic              ic_grant_r, ic_grant_next;
    logic              dc_grant_r, dc_grant_next;
    logic              pick_dc;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
    // 1 = dcache was granted most recently; reset means "icache served last".
    logic last_dc, last_dc_next;

    always_comb begin
        pick_dc = dc_req && (!ic_req || !last_dc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_dc <= 1'b0;
        end else begin
            last_dc <= last_dc_next;
        end
    end
`else
    always_comb begin
        pick_dc = dc_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= '0;
            base       <= '0;
            we_r       <= 1'b0;
            dc_served  <= 1'b0;
            ic_grant_r <= 1'b0;
            dc_grant_r <= 1'b0;
        end else begin
            state      <= state_next;
            beat       <= beat_next;
            base       <= base_next;
            we_r       <= we_next;
            dc_served  <= dc_served_next;
            ic_grant_r <= ic_grant_next;
            dc_grant_r <= dc_grant_next;
        end
    end

    always_comb begin
        state_next     = state;
        beat_next      = beat;
        base_next      = base;
        we_next        = we_r;
        dc_served_next = dc_served;
        ic_grant_next  = 1'b0;
        dc_grant_next  = 1'b0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        last_dc_next   = last_dc;
`endif
        case (state)
            IDLE: begin
                if (ic_req || dc_req) begin
                    beat_next      = '0;
                    dc_served_next = pick_dc;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
                    last_dc_next   = pick_dc;
`endif
                    if (pick_dc) begin
                        state_next    = DC_BURST;
                        base_next     = {dc_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                        we_next       = dc_we;
                        dc_grant_next = 1'b1;
                    end else begin
                        state_next    = IC_BURST;
                        base_next     = {ic_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                        we_next       = 1'b0;
                        ic_grant_next = 1'b1;
                    end
                end
            end
            IC_BURST, DC_BURST: begin
                if (mem_ack) begin
                    if (beat == LAST_BEAT) begin
                        beat_next  = '0;
                        state_next = DONE;
                    end else begin
                        beat_next = beat + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Data paths are gated by state so every output is 0 outside a burst,
    // including while reset holds the arbiter idle.
    logic in_burst, ic_side, dc_rd_side, dc_wr_side;

    always_comb begin
        in_burst   = (state == IC_BURST) || (state == DC_BURST);
        ic_side    = (state == IC_BURST);
        dc_rd_side = (state == DC_BURST) && !we_r;
        dc_wr_side = (state == DC_BURST) && we_r;

        mem_req    = in_burst;
        mem_we     = in_burst && we_r;
        mem_addr   = in_burst ? (base + ADDR_W'({beat, 2'b00})) : '0;
        mem_wdata  = dc_wr_side ? dc_wdata : '0;

        ic_grant   = ic_grant_r;
        ic_rvalid  = ic_side && mem_ack;
        ic_rdata   = ic_side ? mem_rdata : '0;
        ic_done    = (state == DONE) && !dc_served;

        dc_grant   = dc_grant_r;
        dc_rvalid  = dc_rd_side && mem_ack;
        dc_rdata   = dc_rd_side ? mem_rdata : '0;
        dc_wready  = dc_wr_side && mem_ack;
        dc_done    = (state == DONE) && dc_served;

        transfer_in_progress = (state != IDLE);
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - randomized self-checking bench for dram_arbiter
module tb_dram_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam logic [AW-1:0] LINE_MASK = AW'(BL * 4 - 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req, dc_req, dc_we, mem_ack;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [DW-1:0] dc_wdata, mem_rdata;
    logic          ic_grant, ic_rvalid, ic_done;
    logic          dc_wready, dc_grant, dc_rvalid, dc_done;
    logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
    logic          mem_req, mem_we, tip;
    logic [AW-1:0] mem_addr;
    logic [117:0]  all_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_last_dc = 1'b0;

    always #5 clk = ~clk;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant),
        .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wready(dc_wready), .dc_grant(dc_grant), .dc_rvalid(dc_rvalid),
        .dc_rdata(dc_rdata), .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .transfer_in_progress(tip)
    );

    assign all_out = {ic_grant, ic_rvalid, ic_rdata, ic_done, dc_wready, dc_grant,
                      dc_rvalid, dc_rdata, dc_done, mem_req, mem_we, mem_addr,
                      mem_wdata, tip};

    // Arbitration rule: a lone request always wins; on a tie the dcache wins
    // unless round-robin is enabled and the dcache was served last.
    function automatic bit winner_dc(input bit ic, input bit dc);
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        return dc && (!ic || !m_last_dc);
`else
        return dc;
`endif
    endfunction

    // Called one step after a clock edge with the arbiter idle. ack_pct < 0
    // acks every other cycle starting with the second burst cycle.
    task automatic do_burst(input bit ic, input bit dc, input logic [AW-1:0] ia,
                            input logic [AW-1:0] da, input bit we, input int ack_pct,
                            input int drop_beat, output int ncyc);
        bit            wdc;
        logic [AW-1:0] base, exp_addr;
        int            b, cyc;
        wdc = winner_dc(ic, dc);
        m_last_dc = wdc;
        base = (wdc ? da : ia) & ~LINE_MASK;
        ic_req = ic; dc_req = dc; ic_addr = ia; dc_addr = da; dc_we = we;
        mem_ack = 1'($urandom % 2);
        @(posedge clk); #1;
        b = 0; cyc = 0;
        while (b < BL && cyc < 200) begin
            if (b >= drop_beat) begin ic_req = 1'b0; dc_req = 1'b0; end
            if (ack_pct < 0) mem_ack = cyc[0];
            else mem_ack = (int'($urandom % 100) < ack_pct);
            mem_rdata = $urandom; dc_wdata = $urandom;
            #1;
            n_checks++;
            if (ic_grant !== (cyc == 0 && !wdc) || dc_grant !== (cyc == 0 && wdc)) begin
                n_fail++; $display("FAIL grant cyc=%0d: ic=%b dc=%b, want dc_win=%b", cyc, ic_grant, dc_grant, wdc);
            end
            n_checks++;
            if (mem_req !== 1'b1 || tip !== 1'b1) begin
                n_fail++; $display("FAIL busy: mem_req=%b tip=%b, want 1 1", mem_req, tip);
            end
            exp_addr = base + AW'(b * 4);
            n_checks++;
            if (mem_addr !== exp_addr) begin
                n_fail++; $display("FAIL mem_addr beat %0d: got %h want %h", b, mem_addr, exp_addr);
            end
            n_checks++;
            if (mem_we !== (wdc && we)) begin
                n_fail++; $display("FAIL mem_we: got %b want %b", mem_we, wdc && we);
            end
            n_checks++;
            if (ic_rvalid !== (!wdc && mem_ack) || dc_rvalid !== (wdc && !we && mem_ack)
                || dc_wready !== (wdc && we && mem_ack)) begin
                n_fail++; $display("FAIL strobes: ic_rvalid=%b dc_rvalid=%b dc_wready=%b ack=%b",
                                   ic_rvalid, dc_rvalid, dc_wready, mem_ack);
            end
            if (mem_ack && !wdc) begin
                n_checks++;
                if (ic_rdata !== mem_rdata) begin
                    n_fail++; $display("FAIL ic_rdata: got %h want %h", ic_rdata, mem_rdata);
                end
            end
            if (mem_ack && wdc && !we) begin
                n_checks++;
                if (dc_rdata !== mem_rdata) begin
                    n_fail++; $display("FAIL dc_rdata: got %h want %h", dc_rdata, mem_rdata);
                end
            end
            if (wdc && we) begin
                n_checks++;
                if (mem_wdata !== dc_wdata) begin
                    n_fail++; $display("FAIL mem_wdata: got %h want %h", mem_wdata, dc_wdata);
                end
            end
            if (mem_ack) b++;
            cyc++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (b != BL) begin
            n_fail++; $display("FAIL burst timeout: beats %0d want %0d", b, BL);
        end
        // Done cycle: a stray ack here must be ignored.
        ic_req = 1'b0; dc_req = 1'b0;
        mem_ack = 1'($urandom % 2);
        #1;
        n_checks++;
        if (ic_done !== !wdc || dc_done !== wdc || mem_req !== 1'b0 || tip !== 1'b1
            || ic_rvalid !== 1'b0 || dc_rvalid !== 1'b0 || dc_wready !== 1'b0) begin
            n_fail++; $display("FAIL done cycle: ic_done=%b dc_done=%b mem_req=%b tip=%b, want %b %b 0 1",
                               ic_done, dc_done, mem_req, tip, !wdc, wdc);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        n_checks++;
        if (tip !== 1'b0 || ic_done !== 1'b0 || dc_done !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL back to idle: tip=%b ic_done=%b dc_done=%b mem_req=%b, want 0",
                               tip, ic_done, dc_done, mem_req);
        end
        ncyc = cyc + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ack = 1'b1;
        ic_addr = '0; dc_addr = '0; dc_wdata = $urandom; mem_rdata = $urandom;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset outputs: got %h want 0", all_out);
        end
        reset = 1'b0; mem_ack = 1'b0;
        m_last_dc = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        int n;
        for (int i = 0; i < 3; i++)
            do_burst(1'b1, 1'b1, AW'($urandom), AW'($urandom), 1'($urandom % 2), 100, 0, n);
    endtask

    task automatic test_icache_read();
        int n;
        do_burst(1'b1, 1'b0, 12'h01C, 12'h000, 1'b0, 100, 0, n);
        n_checks++;
        if (n != BL + 1) begin
            n_fail++; $display("FAIL tip duration: got %0d cycles want %0d", n, BL + 1);
        end
    endtask

    task automatic test_dcache_writeback();
        int n;
        do_burst(1'b0, 1'b1, 12'h000, 12'hFF4, 1'b1, -1, 0, n);
        n_checks++;
        if (n != 2 * BL + 1) begin
            n_fail++; $display("FAIL alternate-ack duration: got %0d want %0d", n, 2 * BL + 1);
        end
    endtask

    task automatic test_drop_mid();
        int n;
        do_burst(1'b0, 1'b1, AW'($urandom), AW'($urandom), 1'b0, 100, 2, n);
    endtask

    task automatic test_mid_reset();
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 12'h123; mem_ack = 1'b0;
        @(posedge clk); #1;
        dc_req = 1'b0; mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        n_checks++;
        if (mem_addr !== 12'h128 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL beat 2 before reset: addr=%h req=%b want 128 1", mem_addr, mem_req);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
        m_last_dc = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL after mid-burst reset: outputs %h want 0", all_out);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        n_checks++;
        if (dc_done !== 1'b0 || ic_done !== 1'b0 || tip !== 1'b0) begin
            n_fail++; $display("FAIL no done after reset: dc_done=%b ic_done=%b tip=%b", dc_done, ic_done, tip);
        end
    endtask

    task automatic test_stray_ack();
        int n;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
            #1;
            n_checks++;
            if (ic_rvalid !== 1'b0 || dc_rvalid !== 1'b0 || dc_wready !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++; $display("FAIL stray ack: ic_rvalid=%b dc_rvalid=%b dc_wready=%b mem_req=%b",
                                   ic_rvalid, dc_rvalid, dc_wready, mem_req);
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        // Beat counter must still be 0: first address of the next burst is the base.
        do_burst(1'b1, 1'b0, AW'($urandom), 12'h000, 1'b0, 70, 0, n);
    endtask

    task automatic test_random();
        bit ic, dc;
        int n;
        for (int i = 0; i < 20; i++) begin
            ic = 1'($urandom % 2);
            dc = 1'($urandom % 2);
            if (!ic && !dc) ic = 1'b1;
            do_burst(ic, dc, AW'($urandom), AW'($urandom), 1'($urandom % 2),
                     int'($urandom_range(30, 100)), int'($urandom_range(0, BL)), n);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_icache_read();
        test_dcache_writeback();
        test_drop_mid();
        test_mid_reset();
        test_stray_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
